mult_ctrl_16: RTL and testbench

Sequencing controller for the 16-bit shift-add multiplier datapath (`mult_dp_16`) in the ALU's 16-bit multiplier. It accepts a start request, issues the load strobes, and runs 16 conditional add-and-shift iterations by watching the datapath's LSB and iteration counter. It then pulses `done` for one cycle. The multiplier top level joins this controller, the datapath and the 16-bit adder.

---
 rtl/mult_ctrl_16_pkg.sv | 15 +
 rtl/mult_ctrl_16.sv | 100 ++++++++++
 tb/tb_mult_ctrl_16.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mult_ctrl_16_pkg.sv
// Shared definitions for the 16-bit shift-add multiplier: controller state
// encoding and the operand/counter widths used by controller and datapath.
package mult_ctrl_16_pkg;

  localparam int unsigned MULT_N_BITS = 16;
  localparam int unsigned MULT_CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } mult_state_e;

endpackage : mult_ctrl_16_pkg

// File: rtl/mult_ctrl_16.sv
// Sequencing FSM for the shift-add multiplier datapath: load, N_BITS
// conditional add-and-shift steps, then a one-cycle done pulse.
module mult_ctrl_16
  import mult_ctrl_16_pkg::*;
#(
  parameter int unsigned N_BITS = MULT_N_BITS,
  parameter int unsigned CNT_W  = MULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             ls_bit,
  input  logic [CNT_W-1:0] counter_in,
  output logic             ready,
  output logic             done,
  output logic             rt_shift_reg,
  output logic             rt_multiplicand,
  output logic             rt_counter,
  output logic             sl_shift,
  output logic             wr_shift_reg,
  output logic             wr_counter
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);

  mult_state_e r_state;
  mult_state_e w_state_nxt;

  logic r_ready,     w_ready_nxt;
  logic r_done,      w_done_nxt;
  logic r_load,      w_load_nxt;
  logic r_run,       w_run_nxt;
  logic w_last_iter;

  // >= rather than == so an out-of-range counter still terminates RUN
  assign w_last_iter = (counter_in >= LAST_CNT);

  // State and state-decoded strobes registered together from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_load  <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
      r_load  <= w_load_nxt;
      r_run   <= w_run_nxt;
    end
  end

  // Next-state logic and decode of the strobes for the state being entered
  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_load_nxt  = 1'b0;
    w_run_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last_iter) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    case (w_state_nxt)
      ST_IDLE: w_ready_nxt = 1'b1;
      ST_LOAD: w_load_nxt  = 1'b1;
      ST_RUN:  w_run_nxt   = 1'b1;
      ST_DONE: w_done_nxt  = 1'b1;
      default: w_ready_nxt = 1'b1;
    endcase
  end

  assign ready           = r_ready;
  assign done            = r_done;
  assign rt_shift_reg    = r_load;
  assign rt_multiplicand = r_load;
  assign rt_counter      = r_load;
  assign sl_shift        = r_run;
  assign wr_counter      = r_run;

  // Only Mealy output: add-and-shift when the current multiplier LSB is set
  assign wr_shift_reg = r_run & ls_bit;

  a_load_vs_shift : assert property (@(posedge clock) disable iff (reset)
    !((rt_shift_reg | rt_multiplicand | rt_counter) && (sl_shift | wr_shift_reg)));

  a_counter_excl : assert property (@(posedge clock) disable iff (reset)
    !(rt_counter && wr_counter));

  a_done_single : assert property (@(posedge clock) disable iff (reset)
    done |=> !done);

endmodule : mult_ctrl_16

// File: tb/tb_mult_ctrl_16.sv
// Bench for mult_ctrl_16 with a behavioural shift-add datapath and adder
// around it; products and strobe timelines come from operand arithmetic.
module tb_mult_ctrl_16;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        ls_bit;
  logic [4:0]  counter_in;
  logic        ready, done, rt_shift_reg, rt_multiplicand, rt_counter;
  logic        sl_shift, wr_shift_reg, wr_counter;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mult_ctrl_16 dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .ls_bit          (ls_bit),
    .counter_in      (counter_in),
    .ready           (ready),
    .done            (done),
    .rt_shift_reg    (rt_shift_reg),
    .rt_multiplicand (rt_multiplicand),
    .rt_counter      (rt_counter),
    .sl_shift        (sl_shift),
    .wr_shift_reg    (wr_shift_reg),
    .wr_counter      (wr_counter)
  );

  // Datapath + adder environment: 32-bit product/multiplier register
  logic [15:0] op_mc = 16'h0;
  logic [15:0] op_mp = 16'h0;
  logic [31:0] dp_p  = 32'h0;
  logic [15:0] dp_m  = 16'h0;
  logic [4:0]  dp_cnt = 5'h0;
  logic [15:0] dp_sum;

  assign dp_sum     = dp_p[31:16] + dp_m;
  assign ls_bit     = dp_p[0];
  assign counter_in = dp_cnt;

  always @(posedge clock) begin
    if (rt_shift_reg) dp_p <= {16'h0, op_mp};
    else if (sl_shift) dp_p <= wr_shift_reg ? {1'b0, dp_sum, dp_p[15:1]} : {1'b0, dp_p[31:1]};
    if (rt_multiplicand) dp_m <= op_mc;
    if (rt_counter) dp_cnt <= 5'h0;
    else if (wr_counter) dp_cnt <= dp_cnt + 5'd1;
  end

  logic [7:0] act;
  assign act = {ready, done, rt_shift_reg, rt_multiplicand, rt_counter,
                sl_shift, wr_shift_reg, wr_counter};

  // Expected strobes for phase p after acceptance: 0 LOAD, 1..16 RUN, 17 DONE, 18 IDLE
  function automatic logic [7:0] exp_vec(input int p, input logic [15:0] mp);
    logic [15:0] m;
    m = mp;
    if (p == 0)       return 8'b0011_1000;
    else if (p <= 16) return {5'b00000, 1'b1, m[p-1], 1'b1};
    else if (p == 17) return 8'b0100_0000;
    else              return 8'b1000_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Caller has set operands and start=1 at a negedge; next posedge accepts.
  task automatic walk(input string tag, input logic [31:0] want, input int poke1, input int poke2);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clock);
      start = (k == poke1) || (k == poke2);
      chk($sformatf("%s_k%0d", tag, k), 32'(act), 32'(exp_vec(k - 1, op_mp)));
      if (k == 18) chk({tag, "_result"}, dp_p, want);
    end
    @(negedge clock);
    chk({tag, "_idle_after"}, 32'(act), 32'h80);
  endtask

  typedef struct {
    logic [15:0] mc;
    logic [15:0] mp;
    logic [31:0] res;
    int          poke1;
    int          poke2;
    string       tag;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{16'd5,     16'd3,     32'h0000000F, 0, 0,  "m3x5"};
    tbl[1] = '{16'h00FF,  16'h00FF,  32'h0000FE01, 0, 0,  "mFFxFF"};
    tbl[2] = '{16'd11,    16'd13,    32'd143,      7, 18, "poke"};
    tbl[3] = '{16'h7FFF,  16'hFFFF,  32'h7FFE8001, 0, 0,  "maxfit"};

    // Reset held two cycles with start high
    reset = 1'b1;
    start = 1'b1;
    op_mc = tbl[0].mc;
    op_mp = tbl[0].mp;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk($sformatf("reset_%0d", i), 32'(act), 32'h80);
    end
    reset = 1'b0;
    walk(tbl[0].tag, tbl[0].res, tbl[0].poke1, tbl[0].poke2);

    for (int i = 1; i < 4; i++) begin
      op_mc = tbl[i].mc;
      op_mp = tbl[i].mp;
      start = 1'b1;
      walk(tbl[i].tag, tbl[i].res, tbl[i].poke1, tbl[i].poke2);
    end

    // start held for 60 cycles: back-to-back runs every 19 cycles
    op_mc = 16'd6;
    op_mp = 16'h00A5;
    start = 1'b1;
    for (int k = 1; k <= 76; k++) begin
      @(negedge clock);
      if (k == 60) start = 1'b0;
      chk($sformatf("held_k%0d", k), 32'(act), 32'(exp_vec((k - 1) % 19, op_mp)));
      if ((k - 1) % 19 == 17) chk($sformatf("held_res_k%0d", k), dp_p, 32'd990);
    end
    @(negedge clock);
    chk("held_idle_after", 32'(act), 32'h80);

    // Reset for one cycle during RUN with counter 7
    op_mc = 16'd100;
    op_mp = 16'd200;
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      start = 1'b0;
      chk($sformatf("abort_k%0d", k), 32'(act), 32'(exp_vec(k - 1, op_mp)));
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_idle", 32'(act), 32'h80);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk($sformatf("abort_quiet_%0d", i), 32'(act), 32'h80);
    end
    op_mc = 16'd9;
    op_mp = 16'd7;
    start = 1'b1;
    walk("after_abort", 32'h0000003F, 0, 0);

    // Random operands with multiplicand below 2^15 so partial sums fit
    for (int i = 0; i < 8; i++) begin
      op_mc = 16'($urandom_range(0, 32767));
      op_mp = 16'($urandom_range(0, 65535));
      start = 1'b1;
      walk($sformatf("rand%0d", i), 32'(op_mc) * 32'(op_mp), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mult_ctrl_16
